// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory stream loader: loader FSM
// encoding and the default framing byte codes.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ESC  = 2'd2
    } load_state_t;

    localparam logic [7:0] DEF_SOF_CODE = 8'hFE;
    localparam logic [7:0] DEF_EOF_CODE = 8'hFF;
    localparam logic [7:0] DEF_ESC_CODE = 8'hFD;

endpackage

// File: rtl/instr_mem_word_assembler.sv
// Packs accepted data bytes into 32-bit words and strobes each full word.
// A flush with a partly filled word emits it with the unfilled lanes zero.
module instr_mem_word_assembler #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        data_en,
    input  logic [7:0]  data_byte,
    input  logic        flush,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        partial
);

    logic [1:0]  byte_cnt;
    logic [1:0]  lane;
    logic [31:0] shadow;
    logic [31:0] merged;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        lane   = MSB_FIRST ? (2'd3 - byte_cnt) : byte_cnt;
        merged = shadow;
        merged[{lane, 3'b000} +: 8] = data_byte;
    end

    // The word written on the 4th byte already contains that byte.
    assign partial    = flush && (byte_cnt != 2'd0);
    assign word_valid = (data_en && (byte_cnt == 2'd3)) || partial;
    assign word       = data_en ? merged : shadow;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear || flush) begin
            byte_cnt <= 2'd0;
            shadow   <= '0;
        end else if (data_en) begin
            byte_cnt <= byte_cnt + 2'd1;
            shadow   <= (byte_cnt == 2'd3) ? '0 : merged;
        end
    end

endmodule

// File: rtl/instr_mem_stream_loader.sv
// Instruction memory with an asynchronous (or optionally registered) fetch port
// and a framed byte-serial loader with escape, overflow and partial-word errors.
module instr_mem_stream_loader
    import imem_pkg::*;
#(
    parameter int         DEPTH     = 64,
    parameter bit         MSB_FIRST = 1'b1,
    parameter logic [7:0] SOF_CODE  = DEF_SOF_CODE,
    parameter logic [7:0] EOF_CODE  = DEF_EOF_CODE,
    parameter logic [7:0] ESC_CODE  = DEF_ESC_CODE,
    parameter bit         REG_READ  = 1'b0,
    localparam int        ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_byte_i,
    output logic              ld_ready_o,
    input  logic [31:0]       addr_i,
    output logic [31:0]       instr_o,
    output logic              load_busy_o,
    output logic              load_done_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              ld_err_o,
    input  logic              err_clr_i
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    load_state_t     state;
    logic [ADDR_W:0] wr_ptr;
    logic [31:0]     mem [DEPTH];

    logic accept, is_ctrl, is_data, full;
    logic data_en, overflow, resync, eof, store;
    logic [31:0] word;
    logic word_valid, partial;

    assign accept   = ld_valid_i && ld_ready_o;
    assign is_ctrl  = (ld_byte_i == SOF_CODE) || (ld_byte_i == EOF_CODE) ||
                      (ld_byte_i == ESC_CODE);
    assign is_data  = accept && ((state == ESC) || ((state == LOAD) && !is_ctrl));
    assign full     = (wr_ptr == FULL);
    assign data_en  = is_data && !full;
    assign overflow = is_data && full;
    assign resync   = accept && (ld_byte_i == SOF_CODE) && (state != ESC);
    assign eof      = accept && (state == LOAD) && (ld_byte_i == EOF_CODE);
    assign store    = word_valid && !full;

    instr_mem_word_assembler #(
        .MSB_FIRST (MSB_FIRST)
    ) u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (resync),
        .data_en    (data_en),
        .data_byte  (ld_byte_i),
        .flush      (eof),
        .word       (word),
        .word_valid (word_valid),
        .partial    (partial)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            word_count_o <= '0;
            ld_ready_o   <= 1'b0;
            load_done_o  <= 1'b0;
            ld_err_o     <= 1'b0;
        end else begin
            ld_ready_o  <= 1'b1;
            load_done_o <= 1'b0;

            // A new error wins over a clear in the same cycle.
            if (overflow || partial) ld_err_o <= 1'b1;
            else if (err_clr_i)      ld_err_o <= 1'b0;

            if (store) begin
                wr_ptr       <= wr_ptr + 1'b1;
                word_count_o <= word_count_o + 1'b1;
            end
            if (resync) begin
                wr_ptr       <= '0;
                word_count_o <= '0;
            end

            unique case (state)
                IDLE: if (resync) state <= LOAD;
                LOAD: begin
                    if (eof) begin
                        state       <= IDLE;
                        load_done_o <= 1'b1;
                    end else if (accept && (ld_byte_i == ESC_CODE)) begin
                        state <= ESC;
                    end
                end
                ESC:     if (accept) state <= LOAD;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the memory array has no reset; word_count_o gates every fetch, so
    // stale contents are never visible.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr[ADDR_W-1:0]] <= word;
    end

    assign load_busy_o = (state != IDLE);

    logic [ADDR_W-1:0] idx;
    logic [31:0]       fetch_word;
    logic              unused_addr_lsbs;

    assign idx              = addr_i[ADDR_W+1:2];
    assign unused_addr_lsbs = ^addr_i[1:0];

    always_comb begin
        fetch_word = '0;
        if (!load_busy_o && ({1'b0, idx} < word_count_o) && (addr_i[31:ADDR_W+2] == '0))
            fetch_word = mem[idx];
    end

    generate
        if (REG_READ) begin : g_reg_read
            always_ff @(posedge clk) begin
                if (reset) instr_o <= '0;
                else       instr_o <= fetch_word;
            end
        end else begin : g_comb_read
            assign instr_o = fetch_word;
        end
    endgenerate

endmodule

// File: tb/tb_instr_mem_stream_loader.sv
// Self-checking bench: a frame-level model predicts every output each cycle,
// and directed frames pin hand-computed word values.
module tb_instr_mem_stream_loader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam bit MSB    = 1'b1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ld_valid = 1'b0;
    logic [7:0]        ld_byte = 8'h00;
    logic              ld_ready;
    logic [31:0]       addr = 32'h0;
    logic [31:0]       instr;
    logic              load_busy;
    logic              load_done;
    logic [ADDR_W:0]   word_count;
    logic              ld_err;
    logic              err_clr = 1'b0;

    always #5 clk = ~clk;

    instr_mem_stream_loader #(
        .DEPTH     (DEPTH),
        .MSB_FIRST (MSB),
        .SOF_CODE  (8'hFE),
        .EOF_CODE  (8'hFF),
        .ESC_CODE  (8'hFD),
        .REG_READ  (1'b0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ld_valid_i   (ld_valid),
        .ld_byte_i    (ld_byte),
        .ld_ready_o   (ld_ready),
        .addr_i       (addr),
        .instr_o      (instr),
        .load_busy_o  (load_busy),
        .load_done_o  (load_done),
        .word_count_o (word_count),
        .ld_err_o     (ld_err),
        .err_clr_i    (err_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a queue of pending bytes per word, an escape flag,
    // and the list of completed words.
    bit          m_started = 0;
    bit          m_ready, m_busy, m_done, m_err, m_esc;
    int          m_count;
    logic [7:0]  m_q[$];
    logic [31:0] m_mem[DEPTH];

    function automatic logic [31:0] pack_word(input logic [7:0] b0, b1, b2, b3);
        return MSB ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
    endfunction

    task automatic model_commit_word();
        while (m_q.size() < 4) m_q.push_back(8'h00);
        m_mem[m_count] = pack_word(m_q[0], m_q[1], m_q[2], m_q[3]);
        m_count++;
        m_q.delete();
    endtask

    task automatic model_data(input logic [7:0] b);
        if (m_count == DEPTH) begin
            m_err = 1;
        end else begin
            m_q.push_back(b);
            if (m_q.size() == 4) model_commit_word();
        end
    endtask

    always @(posedge clk) begin
        m_started = 1;
        if (reset) begin
            m_ready = 0; m_busy = 0; m_done = 0; m_err = 0; m_esc = 0;
            m_count = 0;
            m_q.delete();
        end else begin
            m_done = 0;
            if (err_clr) m_err = 0;
            if (m_ready && ld_valid) begin
                if (!m_busy) begin
                    if (ld_byte == 8'hFE) begin
                        m_busy = 1; m_count = 0; m_esc = 0; m_q.delete();
                    end
                end else if (m_esc) begin
                    model_data(ld_byte);
                    m_esc = 0;
                end else if (ld_byte == 8'hFE) begin
                    m_count = 0; m_q.delete();
                end else if (ld_byte == 8'hFF) begin
                    if (m_q.size() != 0) begin
                        model_commit_word();
                        m_err = 1;
                    end
                    m_busy = 0; m_done = 1;
                end else if (ld_byte == 8'hFD) begin
                    m_esc = 1;
                end else begin
                    model_data(ld_byte);
                end
            end
            m_ready = 1;
        end
    end

    function automatic logic [31:0] model_fetch(input logic [31:0] a);
        if (m_busy || (a / 4) >= 32'(m_count)) return 32'h0;
        return m_mem[a / 4];
    endfunction

    always @(negedge clk) begin
        if (m_started) begin
            check("ld_ready",   {31'b0, ld_ready},   {31'b0, m_ready});
            check("load_busy",  {31'b0, load_busy},  {31'b0, m_busy});
            check("load_done",  {31'b0, load_done},  {31'b0, m_done});
            check("ld_err",     {31'b0, ld_err},     {31'b0, m_err});
            check("word_count", 32'(word_count),     32'(m_count));
            check("instr",      instr,               model_fetch(addr));
        end
    end

    task automatic send(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_byte  = b;
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fetch_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, instr, exp);
    endtask

    logic [7:0] seq[$];

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(1);
        check("reset_ready", {31'b0, ld_ready}, 32'h1);
        check("reset_count", 32'(word_count), 32'h0);
        fetch_lit("reset_fetch0", 32'h0, 32'h0);

        seq = '{8'hFE, 8'h00, 8'h00, 8'h00, 8'h13, 8'hFF};
        send_seq(seq);
        check("done_pulse", {31'b0, load_done}, 32'h1);
        idle(1);
        check("done_cleared", {31'b0, load_done}, 32'h0);
        check("one_word_count", 32'(word_count), 32'h1);
        fetch_lit("one_word_fetch0", 32'h0, 32'h0000_0013);
        fetch_lit("one_word_fetch4", 32'h4, 32'h0);

        seq = '{8'hFE, 8'hFD, 8'hFF, 8'h11, 8'h22, 8'h33, 8'hFF};
        send_seq(seq);
        idle(1);
        fetch_lit("escaped_word", 32'h0, 32'hFF11_2233);
        check("escaped_no_err", {31'b0, ld_err}, 32'h0);

        seq = '{8'hFE, 8'hAA, 8'hBB, 8'hFF};
        send_seq(seq);
        idle(1);
        fetch_lit("partial_word", 32'h3, 32'hAABB_0000);
        check("partial_count", 32'(word_count), 32'h1);
        check("partial_err", {31'b0, ld_err}, 32'h1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("err_cleared", {31'b0, ld_err}, 32'h0);

        send(8'hFE);
        for (int i = 1; i <= 20; i++) begin
            send(8'(i));
            if (i == 6) begin
                check("busy_mid_frame", {31'b0, load_busy}, 32'h1);
                fetch_lit("fetch_while_busy", 32'h0, 32'h0);
            end
        end
        send(8'hFF);
        idle(1);
        check("overflow_count", 32'(word_count), 32'h4);
        check("overflow_err", {31'b0, ld_err}, 32'h1);
        fetch_lit("overflow_w0", 32'h0, 32'h0102_0304);
        fetch_lit("overflow_w1", 32'h4, 32'h0506_0708);
        fetch_lit("overflow_w2", 32'h8, 32'h090A_0B0C);
        fetch_lit("overflow_w3", 32'hC, 32'h0D0E_0F10);
        fetch_lit("overflow_beyond", 32'h10, 32'h0);
        fetch_lit("high_addr_bits", 32'h8000_0000, 32'h0);

        seq = '{8'hFE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_seq(seq);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("midreset_count", 32'(word_count), 32'h0);
        check("midreset_busy", {31'b0, load_busy}, 32'h0);
        fetch_lit("midreset_fetch0", 32'h0, 32'h0);
        fetch_lit("midreset_fetch4", 32'h4, 32'h0);
        idle(1);
        seq = '{8'hFE, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF};
        send_seq(seq);
        idle(1);
        fetch_lit("after_reset_w0", 32'h0, 32'hA1A2_A3A4);

        seq = '{8'h11, 8'h22, 8'hFE, 8'h11, 8'h22, 8'hFE, 8'h33, 8'h44,
                8'hFD, 8'hFE, 8'h66, 8'hFF};
        send_seq(seq);
        idle(1);
        fetch_lit("resync_w0", 32'h0, 32'h3344_FE66);
        check("resync_count", 32'(word_count), 32'h1);
        check("resync_no_err", {31'b0, ld_err}, 32'h0);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
